// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects EX/WB read-after-write, multi-cycle ALU
// and memory-read stalls, drives stage enables and counts stalled cycles.
// Ports:
//   clk, rst (async, active-high)
//   id_*  stage-0 reads (W / Ri / CY), source regs ra/rb, memory read
//   ex_*  stage-1 writes (W / Ri / CY), dest reg rc, multi-cycle op flag
//   wb_*  stage-2 writes (W / Ri / CY), dest reg rc
//   flush aborts any stall at the next edge
//   en0/en1 stage advance enables, state (00 IDLE 01 RAW 10 MC 11 MEM),
//   stall_cnt counts cycles with en0 low (saturating)
module hazard_ctrl #(
  parameter int RA_W       = 5,
  parameter int MC_CYCLES  = 3,
  parameter int MEM_CYCLES = 3,
  parameter int FWD_EN     = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_rd_w,
  input  logic             id_rd_r,
  input  logic             id_rd_cy,
  input  logic [RA_W-1:0]  id_ra,
  input  logic [RA_W-1:0]  id_rb,
  input  logic             id_mem_rd,
  input  logic             ex_wr_w,
  input  logic             ex_wr_r,
  input  logic             ex_wr_cy,
  input  logic [RA_W-1:0]  ex_rc,
  input  logic             ex_mc,
  input  logic             wb_wr_w,
  input  logic             wb_wr_r,
  input  logic             wb_wr_cy,
  input  logic [RA_W-1:0]  wb_rc,
  input  logic             flush,
  output logic             en0,
  output logic             en1,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RAW  = 2'b01,
    MC   = 2'b10,
    MEM  = 2'b11
  } state_t;

  localparam logic [3:0] MC_LEN  = 4'(MC_CYCLES - 1);
  localparam logic [3:0] MEM_LEN = 4'(MEM_CYCLES - 1);

  state_t           cur, nxt;
  logic             en0_q, en0_d;
  logic             en1_q, en1_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] sc_q, sc_d;
  logic             ex_hz, wb_hz;

  assign ex_hz = (id_rd_w & ex_wr_w)
               | (id_rd_cy & ex_wr_cy)
               | (id_rd_r & ex_wr_r &
                  ((id_ra == ex_rc) | (id_rb == ex_rc)));

  // With forwarding the WB result is bypassed, so no stall is needed.
  assign wb_hz = (FWD_EN == 0) &&
                 ((id_rd_w & wb_wr_w)
                | (id_rd_cy & wb_wr_cy)
                | (id_rd_r & wb_wr_r &
                   ((id_ra == wb_rc) | (id_rb == wb_rc))));

  always_comb begin
    nxt   = cur;
    en0_d = en0_q;
    en1_d = en1_q;
    cnt_d = cnt_q;
    if (flush) begin
      nxt   = IDLE;
      en0_d = 1'b1;
      en1_d = 1'b1;
      cnt_d = 4'd0;
    end else if (cur == IDLE) begin
      if (ex_mc) begin
        nxt   = MC;
        en0_d = 1'b0;
        en1_d = 1'b0;
        cnt_d = MC_LEN;
      end else if (id_mem_rd) begin
        nxt   = MEM;
        en0_d = 1'b0;
        en1_d = 1'b1;
        cnt_d = MEM_LEN;
      end else if (ex_hz) begin
        nxt   = RAW;
        en0_d = 1'b0;
        en1_d = 1'b1;
        cnt_d = 4'd1;
      end else if (wb_hz) begin
        nxt   = RAW;
        en0_d = 1'b0;
        en1_d = 1'b1;
        cnt_d = 4'd0;
      end
    end else begin
      // Leaving a stall lands in IDLE without evaluating, which
      // guarantees one enabled cycle between back-to-back stalls.
      if (cnt_q == 4'd0) begin
        nxt   = IDLE;
        en0_d = 1'b1;
        en1_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  assign sc_d = (!en0_q && (sc_q != {CNT_W{1'b1}}))
              ? sc_q + 1'b1 : sc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur   <= IDLE;
      en0_q <= 1'b1;
      en1_q <= 1'b1;
      cnt_q <= 4'd0;
      sc_q  <= '0;
    end else begin
      cur   <= nxt;
      en0_q <= en0_d;
      en1_q <= en1_d;
      cnt_q <= cnt_d;
      sc_q  <= sc_d;
    end
  end

  assign en0       = en0_q;
  assign en1       = en1_q;
  assign state     = cur;
  assign stall_cnt = sc_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two parameterisations share stimulus,
// a stall-length reference model queues expected outputs per edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_rd_w, id_rd_r, id_rd_cy, id_mem_rd;
  logic [4:0] id_ra, id_rb, ex_rc, wb_rc;
  logic       ex_wr_w, ex_wr_r, ex_wr_cy, ex_mc;
  logic       wb_wr_w, wb_wr_r, wb_wr_cy, flush;

  logic        e0a, e1a, e0b, e1b;
  logic [1:0]  st_a, st_b;
  logic [3:0]  sc_a;
  logic [15:0] sc_b;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .RA_W(5), .MC_CYCLES(3), .MEM_CYCLES(5),
    .FWD_EN(0), .CNT_W(4)
  ) dut_a (
    .clk(clk), .rst(rst),
    .id_rd_w(id_rd_w), .id_rd_r(id_rd_r), .id_rd_cy(id_rd_cy),
    .id_ra(id_ra), .id_rb(id_rb), .id_mem_rd(id_mem_rd),
    .ex_wr_w(ex_wr_w), .ex_wr_r(ex_wr_r), .ex_wr_cy(ex_wr_cy),
    .ex_rc(ex_rc), .ex_mc(ex_mc),
    .wb_wr_w(wb_wr_w), .wb_wr_r(wb_wr_r), .wb_wr_cy(wb_wr_cy),
    .wb_rc(wb_rc), .flush(flush),
    .en0(e0a), .en1(e1a), .state(st_a), .stall_cnt(sc_a)
  );

  hazard_ctrl #(
    .RA_W(5), .MC_CYCLES(4), .MEM_CYCLES(2),
    .FWD_EN(1), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst(rst),
    .id_rd_w(id_rd_w), .id_rd_r(id_rd_r), .id_rd_cy(id_rd_cy),
    .id_ra(id_ra), .id_rb(id_rb), .id_mem_rd(id_mem_rd),
    .ex_wr_w(ex_wr_w), .ex_wr_r(ex_wr_r), .ex_wr_cy(ex_wr_cy),
    .ex_rc(ex_rc), .ex_mc(ex_mc),
    .wb_wr_w(wb_wr_w), .wb_wr_r(wb_wr_r), .wb_wr_cy(wb_wr_cy),
    .wb_rc(wb_rc), .flush(flush),
    .en0(e0b), .en1(e1b), .state(st_b), .stall_cnt(sc_b)
  );

  typedef struct packed {
    logic [1:0]  st;
    logic        e0;
    logic        e1;
    logic [15:0] sc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: rem = stall cycles still to show, kind = 0/1/2/3
  initial begin
    int rem[2];
    int kind[2];
    int sc[2];
    int mc_len[2];
    int mem_len[2];
    int fwd[2];
    int sc_max[2];
    bit exh, wbh, busy;
    exp_t e;
    mc_len  = '{3, 4};
    mem_len = '{5, 2};
    fwd     = '{0, 1};
    sc_max  = '{15, 65535};
    rem     = '{0, 0};
    kind    = '{0, 0};
    sc      = '{0, 0};
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        rem  = '{0, 0};
        kind = '{0, 0};
        sc   = '{0, 0};
      end else begin
        exh = (id_rd_w && ex_wr_w) || (id_rd_cy && ex_wr_cy) ||
              (id_rd_r && ex_wr_r &&
               (id_ra == ex_rc || id_rb == ex_rc));
        wbh = (id_rd_w && wb_wr_w) || (id_rd_cy && wb_wr_cy) ||
              (id_rd_r && wb_wr_r &&
               (id_ra == wb_rc || id_rb == wb_rc));
        for (int i = 0; i < 2; i++) begin
          busy = rem[i] > 0;
          if (busy && sc[i] < sc_max[i]) sc[i] = sc[i] + 1;
          if (flush) begin
            rem[i]  = 0;
            kind[i] = 0;
          end else if (busy) begin
            rem[i] = rem[i] - 1;
            if (rem[i] == 0) kind[i] = 0;
          end else if (ex_mc) begin
            rem[i]  = mc_len[i];
            kind[i] = 2;
          end else if (id_mem_rd) begin
            rem[i]  = mem_len[i];
            kind[i] = 3;
          end else if (exh) begin
            rem[i]  = 2;
            kind[i] = 1;
          end else if (wbh && fwd[i] == 0) begin
            rem[i]  = 1;
            kind[i] = 1;
          end
          e.st = 2'(kind[i]);
          e.e0 = (rem[i] == 0);
          e.e1 = (kind[i] != 2);
          e.sc = 16'(sc[i]);
          if (i == 0) q_a.push_back(e);
          else        q_b.push_back(e);
        end
      end
    end
  end

  task automatic cmp(input string nm, input exp_t act,
                     input exp_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual st=%b en0=%b en1=%b sc=%0d required st=%b en0=%b en1=%b sc=%0d",
               nm, $time, act.st, act.e0, act.e1, act.sc,
               exp.st, exp.e0, exp.e1, exp.sc);
    end
  endtask

  // Monitor: compares on the falling edge, and shortly after rst rises
  initial begin
    exp_t ex, aa, ab, rv;
    rv = '{st: 2'b00, e0: 1'b1, e1: 1'b1, sc: 16'd0};
    forever begin
      @(negedge clk or posedge rst);
      aa = '{st: st_a, e0: e0a, e1: e1a, sc: {12'd0, sc_a}};
      ab = '{st: st_b, e0: e0b, e1: e1b, sc: sc_b};
      if (rst) begin
        #1;
        aa = '{st: st_a, e0: e0a, e1: e1a, sc: {12'd0, sc_a}};
        ab = '{st: st_b, e0: e0b, e1: e1b, sc: sc_b};
        cmp("reset_a", aa, rv);
        cmp("reset_b", ab, rv);
      end else begin
        if (q_a.size() > 0) begin
          ex = q_a.pop_front();
          cmp("dut_a", aa, ex);
        end
        if (q_b.size() > 0) begin
          ex = q_b.pop_front();
          cmp("dut_b", ab, ex);
        end
      end
    end
  end

  task automatic clr();
    id_rd_w = 0; id_rd_r = 0; id_rd_cy = 0; id_mem_rd = 0;
    id_ra = 0; id_rb = 0; ex_rc = 0; wb_rc = 0;
    ex_wr_w = 0; ex_wr_r = 0; ex_wr_cy = 0; ex_mc = 0;
    wb_wr_w = 0; wb_wr_r = 0; wb_wr_cy = 0; flush = 0;
  endtask

  // Addresses mostly differ only in bit 0 / bit 4 to hit
  // near-miss compares across the full width.
  function automatic logic [4:0] ra();
    logic [4:0] v;
    v = '0;
    v[0] = 1'($urandom_range(0, 1));
    v[4] = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) v = 5'($urandom_range(0, 31));
    return v;
  endfunction

  task automatic rnd();
    id_rd_w   = ($urandom_range(0, 3) == 0);
    id_rd_r   = ($urandom_range(0, 1) == 0);
    id_rd_cy  = ($urandom_range(0, 3) == 0);
    id_mem_rd = ($urandom_range(0, 9) == 0);
    ex_wr_w   = ($urandom_range(0, 3) == 0);
    ex_wr_r   = ($urandom_range(0, 1) == 0);
    ex_wr_cy  = ($urandom_range(0, 3) == 0);
    ex_mc     = ($urandom_range(0, 15) == 0);
    wb_wr_w   = ($urandom_range(0, 3) == 0);
    wb_wr_r   = ($urandom_range(0, 1) == 0);
    wb_wr_cy  = ($urandom_range(0, 3) == 0);
    flush     = ($urandom_range(0, 19) == 0);
    id_ra = ra();
    id_rb = ra();
    ex_rc = ra();
    wb_rc = ra();
  endtask

  initial begin
    clr();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // EX Ri hazard
    id_rd_r = 1; id_ra = 5; ex_wr_r = 1; ex_rc = 5;
    @(negedge clk); clr();
    repeat (4) @(negedge clk);
    // WB CY hazard
    id_rd_cy = 1; wb_wr_cy = 1;
    @(negedge clk); clr();
    repeat (3) @(negedge clk);
    // priority: MC beats MEM beats EX hazard
    ex_mc = 1; id_mem_rd = 1; id_rd_w = 1; ex_wr_w = 1;
    @(negedge clk); clr();
    repeat (6) @(negedge clk);
    // flush on second MEM stall cycle
    id_mem_rd = 1;
    @(negedge clk); clr();
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;
    repeat (4) @(negedge clk);
    // async reset pulse during MC
    ex_mc = 1;
    @(negedge clk); clr();
    @(negedge clk);
    #1 rst = 1'b1;
    #3 rst = 1'b0;
    repeat (4) @(negedge clk);
    // held hazard drives stall_cnt into saturation
    id_rd_w = 1; ex_wr_w = 1;
    repeat (50) @(negedge clk);
    clr();
    repeat (3) @(negedge clk);
    repeat (2000) begin
      rnd();
      @(negedge clk);
    end
    clr();
    repeat (6) @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
